cache_refill_buffer: RTL
========================

Name: cache_refill_buffer

Overview:
Line-fill engine between main memory and the L1 cache data array. On a miss, the cache controller hands it a block address. It issues one burst read to memory and assembles the returning BEAT_W-bit beats into a full 512-bit line. It then presents the line to the cache data array with a single-cycle write enable and signals completion back to the controller.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 512, cache line width in bits (64 bytes)
BEAT_W, 64, memory data beat width; LINE_W/BEAT_W = NBEATS = 8
INDEX_W, 6, set index width (64 sets)
OFFSET_W, 6, byte offset within a line

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
fill_req_valid  in  1  controller requests a line fill
fill_req_ready  out  1  buffer idle and able to accept a request
fill_req_addr  in  ADDR_W  miss address (offset bits ignored)
mem_req_valid  out  1  burst read request to memory
mem_req_ready  in  1  memory accepts the request
mem_req_addr  out  ADDR_W  line-aligned burst address
mem_rdata_valid  in  1  one beat valid this cycle
mem_rdata  in  BEAT_W  beat data
line_we  out  1  one-cycle write strobe to the cache data array
line_index  out  INDEX_W  set index for the write
line_data  out  LINE_W  assembled line
fill_done  out  1  one-cycle pulse, same cycle as line_we
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: fill_req_ready=1 (IDLE); mem_req_valid=0; line_we=0; fill_done=0; busy=0; mem_req_addr=0; line_index=0; line_data=0; beat_cnt=0.
- Clock and reset: one clock, clk. rst is synchronous and active-high; it wins over all other inputs.
- FSM states: IDLE, REQ, FILL, WRITE.
- IDLE:
  - fill_req_ready=1.
  - On fill_req_valid, latch addr_q = {fill_req_addr[ADDR_W-1:OFFSET_W], OFFSET_W'b0}, go to REQ.
- REQ:
  - mem_req_valid=1; mem_req_addr=addr_q, held stable until accepted.
  - On mem_req_ready, clear beat_cnt and go to FILL.
  - Any mem_rdata_valid in this state is ignored.
- FILL:
  - On each mem_rdata_valid, write mem_rdata into buffer bits [beat_cnt*BEAT_W +: BEAT_W] and increment beat_cnt.
  - Beat 0 is the lowest-address beat (bits 63:0); beats arrive in ascending address order.
  - Gaps (valid low) are allowed; buffer and beat_cnt hold.
  - When the beat with beat_cnt==NBEATS-1 is accepted, go to WRITE.
- WRITE (exactly one cycle):
  - line_we=1 and fill_done=1.
  - line_index = addr_q[OFFSET_W +: INDEX_W].
  - line_data = buffer; the final beat is already in the register.
  - Next state is IDLE.
- line_data and line_index are registered. They hold their last value outside WRITE; the data array samples them only while line_we=1.
- Latency: with mem_req_ready high in REQ and back-to-back beats, fill_req accepted at cycle T gives:
  - REQ at T+1, FILL at T+2;
  - last beat accepted at T+9;
  - line_we at T+10.
- No new request is accepted until the cycle after WRITE, because fill_req_ready is high only in IDLE. fill_req_valid held high through WRITE is accepted in the following IDLE cycle.
- beat_cnt is log2(NBEATS) bits wide and does not wrap inside a fill; it is cleared on entry to FILL.
- mem_rdata_valid in IDLE or WRITE is ignored; the buffer is unchanged.
- Reset mid-operation (REQ/FILL/WRITE): the next state is IDLE and the partial buffer is discarded; line_we is never asserted for the aborted fill.
- Way selection is not done here: the data array picks the victim way from its lru input at the line_we edge. The controller must hold LRU stable until fill_done.

Decomposition:
- Shared package cache_pkg holds:
  - constants LINE_W, BEAT_W, NBEATS, INDEX_W, OFFSET_W, TAG_W;
  - the refill FSM state enum (IDLE, REQ, FILL, WRITE);
  - address field extraction helpers (tag/index/offset).
- One sub-module is natural: line_assembler. It holds the beat shift-in register and beat counter (inputs beat_valid, beat_data, clr; outputs line, last_beat).
- The top level holds the FSM and handshakes.

Test Plan:
- Basic fill: fill_req_addr=0x0000_1A7C, mem_req_ready=1, beats k=0..7 = 64'h1111_0000_0000_000k back-to-back ->
  - mem_req_addr=0x0000_1A40;
  - line_index=6'h29 (0x1A40>>6 & 0x3F = 41);
  - line_we at T+10;
  - line_data[63:0]=64'h1111_0000_0000_0000 and line_data[511:448]=64'h1111_0000_0000_0007;
  - fill_done coincident with line_we.
- Memory stall: mem_req_ready low for 5 cycles ->
  - mem_req_valid and mem_req_addr stable all 5 cycles;
  - line_we at T+15.
- Beat gaps: valid pattern 1,0,1,0,… for 8 beats -> line identical to the back-to-back case; exactly one line_we pulse.
- Spurious beats: mem_rdata_valid=1 with 64'hDEAD in IDLE and REQ -> not captured; subsequent 8 proper beats give a clean line.
- Reset mid-fill: rst asserted after beat 3 ->
  - next cycle IDLE, fill_req_ready=1, busy=0;
  - no line_we;
  - a new full fill afterwards completes correctly.
- Back-to-back requests: fill_req_valid held high ->
  - second request accepted the cycle after WRITE;
  - fill_req_ready=0 throughout REQ/FILL/WRITE.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants, refill FSM state type and address field helpers
// for the L1 line-fill path.
package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 512;
  localparam int BEAT_W   = 64;
  localparam int NBEATS   = LINE_W / BEAT_W;
  localparam int CNT_W    = $clog2(NBEATS);
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 6;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } refill_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return TAG_W'(addr >> (OFFSET_W + INDEX_W));
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return INDEX_W'(addr >> OFFSET_W);
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return OFFSET_W'(addr);
  endfunction

  // Clear the byte-offset bits so the address points at the start of its line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & {{(ADDR_W - OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_refill_buffer_line_assembler.sv
// Collects memory beats into a full cache line. Beat 0 lands in the lowest
// slot. The line output already contains the beat accepted this cycle, so the
// final beat can be captured downstream on the same edge that stores it here.
module line_assembler
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              beat_valid,
  input  logic [BEAT_W-1:0] beat_data,
  output logic [LINE_W-1:0] line,
  output logic              last_beat
);

  logic [LINE_W-1:0] line_r;
  logic [LINE_W-1:0] line_s;
  logic [CNT_W-1:0]  beat_cnt_r;

  // Merge the incoming beat into the slot selected by the beat counter.
  always_comb begin
    line_s = line_r;
    if (beat_valid) begin
      for (int k = 0; k < NBEATS; k++) begin
        if (beat_cnt_r == CNT_W'(k)) begin
          line_s[k*BEAT_W +: BEAT_W] = beat_data;
        end else begin
          line_s[k*BEAT_W +: BEAT_W] = line_r[k*BEAT_W +: BEAT_W];
        end
      end
    end else begin
      line_s = line_r;
    end
  end

  // Hold the partial line and beat count; reset or a new fill discards both.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      line_r     <= '0;
      beat_cnt_r <= '0;
    end else begin
      line_r <= line_s;
      if (beat_valid) begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end
    end
  end

  assign line      = line_s;
  assign last_beat = beat_valid && (beat_cnt_r == CNT_W'(NBEATS - 1));

endmodule

// File: rtl/cache_refill_buffer.sv
// Line-fill engine: accepts a miss address, issues one burst read, gathers
// the returning beats and writes the finished line to the data array with a
// single-cycle strobe. All outputs come straight from registers.
module cache_refill_buffer
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               fill_req_valid,
  output logic               fill_req_ready,
  input  logic [ADDR_W-1:0]  fill_req_addr,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rdata_valid,
  input  logic [BEAT_W-1:0]  mem_rdata,
  output logic               line_we,
  output logic [INDEX_W-1:0] line_index,
  output logic [LINE_W-1:0]  line_data,
  output logic               fill_done,
  output logic               busy
);

  refill_state_e state_r;
  refill_state_e next_s;

  logic [ADDR_W-1:0]  addr_r;
  logic [INDEX_W-1:0] line_index_r;
  logic [LINE_W-1:0]  line_data_r;
  logic               fill_req_ready_r;
  logic               mem_req_valid_r;
  logic               line_we_r;
  logic               fill_done_r;
  logic               busy_r;

  logic               ready_s;
  logic               req_valid_s;
  logic               we_s;
  logic               busy_s;
  logic               beat_valid_s;
  logic               clr_s;
  logic               last_beat_s;
  logic [LINE_W-1:0]  asm_line_s;

  // Beats count only while filling; the counter restarts as the burst is accepted.
  assign beat_valid_s = mem_rdata_valid && (state_r == FILL);
  assign clr_s        = (state_r == REQ) && mem_req_ready;

  line_assembler u_line_assembler (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr_s),
    .beat_valid (beat_valid_s),
    .beat_data  (mem_rdata),
    .line       (asm_line_s),
    .last_beat  (last_beat_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic for the refill sequence.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (fill_req_valid) next_s = REQ;
        else                next_s = IDLE;
      end
      REQ: begin
        if (mem_req_ready) next_s = FILL;
        else               next_s = REQ;
      end
      FILL: begin
        if (last_beat_s) next_s = WRITE;
        else             next_s = FILL;
      end
      WRITE:   next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Output decode of the upcoming state, so the registered outputs line up with it.
  always_comb begin
    ready_s     = 1'b0;
    req_valid_s = 1'b0;
    we_s        = 1'b0;
    busy_s      = 1'b1;
    case (next_s)
      IDLE: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
      REQ:     req_valid_s = 1'b1;
      FILL:    busy_s      = 1'b1;
      WRITE:   we_s        = 1'b1;
      default: busy_s      = 1'b1;
    endcase
  end

  // Output, address and write-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_req_ready_r <= 1'b1;
      mem_req_valid_r  <= 1'b0;
      line_we_r        <= 1'b0;
      fill_done_r      <= 1'b0;
      busy_r           <= 1'b0;
      addr_r           <= '0;
      line_index_r     <= '0;
      line_data_r      <= '0;
    end else begin
      fill_req_ready_r <= ready_s;
      mem_req_valid_r  <= req_valid_s;
      line_we_r        <= we_s;
      fill_done_r      <= we_s;
      busy_r           <= busy_s;
      if ((state_r == IDLE) && fill_req_valid) begin
        addr_r <= line_align(fill_req_addr);
      end
      // Capture the line (final beat merged in) as the FSM enters WRITE.
      if ((state_r == FILL) && last_beat_s) begin
        line_index_r <= addr_index(addr_r);
        line_data_r  <= asm_line_s;
      end
    end
  end

  assign fill_req_ready = fill_req_ready_r;
  assign mem_req_valid  = mem_req_valid_r;
  assign mem_req_addr   = addr_r;
  assign line_we        = line_we_r;
  assign line_index     = line_index_r;
  assign line_data      = line_data_r;
  assign fill_done      = fill_done_r;
  assign busy           = busy_r;

endmodule
